jt51_cpu_wr: RTL

- Host-side write interface for the JT51 core; the writer counterpart of the operator/channel register file.
- Decodes YM2151-style address/data bus writes.
- Globals (timers, LFO, noise, CT) are written directly into local registers.
- Channel/operator writes are converted into one held `up_*` strobe plus `op`/`ch`/`d_out`, kept stable until the register file has completed its busy window.
- Provides the host status read (busy, timer flags).

---
 rtl/jt51_cpu_wr.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/jt51_cpu_wr.sv
// Host write port of the JT51 core: latches globals locally and hands
// channel/operator writes to the register file through held update strobes.
module jt51_cpu_wr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       busy_in,
    input  logic       flag_A,
    input  logic       flag_B,
    output logic [7:0] d_out,
    output logic [1:0] op,
    output logic [2:0] ch,
    output logic       up_rl,
    output logic       up_kc,
    output logic       up_kf,
    output logic       up_pms,
    output logic       up_dt1,
    output logic       up_tl,
    output logic       up_ks,
    output logic       up_amsen,
    output logic       up_dt2,
    output logic       up_d1l,
    output logic       up_keyon,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       en_irq_A,
    output logic       en_irq_B,
    output logic       csm,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       lfo_rst,
    output logic [7:0] lfo_freq,
    output logic [6:0] amd,
    output logic [6:0] pmd,
    output logic [1:0] lfo_w,
    output logic [1:0] ct,
    output logic       ne,
    output logic [4:0] nfrq
);

    localparam int unsigned NUP      = 11;
    localparam int unsigned UP_RL    = 0;
    localparam int unsigned UP_KC    = 1;
    localparam int unsigned UP_KF    = 2;
    localparam int unsigned UP_PMS   = 3;
    localparam int unsigned UP_DT1   = 4;
    localparam int unsigned UP_TL    = 5;
    localparam int unsigned UP_KS    = 6;
    localparam int unsigned UP_AMSEN = 7;
    localparam int unsigned UP_DT2   = 8;
    localparam int unsigned UP_D1L   = 9;
    localparam int unsigned UP_KEYON = 10;

    typedef enum logic [1:0] {IDLE, ARMED, UPDATE} state_t;

    typedef struct packed {
        logic [9:0] value_a;
        logic [7:0] value_b;
        logic       load_a;
        logic       load_b;
        logic       en_irq_a;
        logic       en_irq_b;
        logic       csm;
        logic       clr_a;
        logic       clr_b;
        logic       lfo_rst;
        logic [7:0] lfo_freq;
        logic [6:0] amd;
        logic [6:0] pmd;
        logic [1:0] lfo_w;
        logic [1:0] ct;
        logic       ne;
        logic [4:0] nfrq;
    } glb_t;

    state_t           state_q, state_d;
    glb_t             glb_q, glb_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       dreg_q, dreg_d;
    logic [1:0]       op_q, op_d;
    logic [2:0]       ch_q, ch_d;
    logic [NUP-1:0]   up_q, up_d;
    logic             we_q;
    logic             busy_in_q;

    logic we_c, wr_ev_c, busy_flag_c, chan_wr_c, glb_wr_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            glb_q     <= '0;
            addr_q    <= '0;
            dreg_q    <= '0;
            op_q      <= '0;
            ch_q      <= '0;
            up_q      <= '0;
            we_q      <= 1'b0;
            busy_in_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            glb_q     <= glb_d;
            addr_q    <= addr_d;
            dreg_q    <= dreg_d;
            op_q      <= op_d;
            ch_q      <= ch_d;
            up_q      <= up_d;
            we_q      <= we_c;
            busy_in_q <= busy_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        glb_d     = glb_q;
        glb_d.clr_a = 1'b0;
        glb_d.clr_b = 1'b0;
        addr_d    = addr_q;
        dreg_d    = dreg_q;
        op_d      = op_q;
        ch_d      = ch_q;
        up_d      = up_q;

        we_c        = ~cs_n & ~wr_n;
        wr_ev_c     = we_c & ~we_q;
        busy_flag_c = (state_q != IDLE);
        chan_wr_c   = wr_ev_c & a0 & ((addr_q >= 8'h20) | (addr_q == 8'h08));
        glb_wr_c    = wr_ev_c & a0 & (addr_q < 8'h20) & (addr_q != 8'h08);

        if (wr_ev_c && !a0) begin
            addr_d = din;
        end

        if (glb_wr_c) begin
            case (addr_q)
                8'h01: glb_d.lfo_rst = din[1];
                8'h0F: begin
                    glb_d.ne   = din[7];
                    glb_d.nfrq = din[4:0];
                end
                8'h10: glb_d.value_a[9:2] = din;
                8'h11: glb_d.value_a[1:0] = din[1:0];
                8'h12: glb_d.value_b = din;
                8'h14: begin
                    glb_d.csm      = din[7];
                    glb_d.clr_b    = din[5];
                    glb_d.clr_a    = din[4];
                    glb_d.en_irq_b = din[3];
                    glb_d.en_irq_a = din[2];
                    glb_d.load_b   = din[1];
                    glb_d.load_a   = din[0];
                end
                8'h18: glb_d.lfo_freq = din;
                8'h19: begin
                    if (din[7]) glb_d.pmd = din[6:0];
                    else        glb_d.amd = din[6:0];
                end
                8'h1B: begin
                    glb_d.ct    = din[7:6];
                    glb_d.lfo_w = din[1:0];
                end
                default: ;
            endcase
        end

        // ARMED waits for a fresh busy_in rise so a stale window cannot end the update
        case (state_q)
            IDLE: begin
                if (chan_wr_c) begin
                    dreg_d = din;
                    op_d   = addr_q[4:3];
                    ch_d   = addr_q[2:0];
                    up_d   = '0;
                    if (addr_q == 8'h08) begin
                        up_d[UP_KEYON] = 1'b1;
                    end else if (addr_q[7:5] == 3'b001) begin
                        case (addr_q[4:3])
                            2'd0:    up_d[UP_RL]  = 1'b1;
                            2'd1:    up_d[UP_KC]  = 1'b1;
                            2'd2:    up_d[UP_KF]  = 1'b1;
                            default: up_d[UP_PMS] = 1'b1;
                        endcase
                    end else begin
                        case (addr_q[7:5])
                            3'd2:    up_d[UP_DT1]   = 1'b1;
                            3'd3:    up_d[UP_TL]    = 1'b1;
                            3'd4:    up_d[UP_KS]    = 1'b1;
                            3'd5:    up_d[UP_AMSEN] = 1'b1;
                            3'd6:    up_d[UP_DT2]   = 1'b1;
                            default: up_d[UP_D1L]   = 1'b1;
                        endcase
                    end
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (busy_in && !busy_in_q) state_d = UPDATE;
            end
            UPDATE: begin
                if (!busy_in) begin
                    up_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout       = {busy_flag_c, 5'b0, flag_B, flag_A};
    assign d_out      = dreg_q;
    assign op         = op_q;
    assign ch         = ch_q;
    assign up_rl      = up_q[UP_RL];
    assign up_kc      = up_q[UP_KC];
    assign up_kf      = up_q[UP_KF];
    assign up_pms     = up_q[UP_PMS];
    assign up_dt1     = up_q[UP_DT1];
    assign up_tl      = up_q[UP_TL];
    assign up_ks      = up_q[UP_KS];
    assign up_amsen   = up_q[UP_AMSEN];
    assign up_dt2     = up_q[UP_DT2];
    assign up_d1l     = up_q[UP_D1L];
    assign up_keyon   = up_q[UP_KEYON];
    assign value_A    = glb_q.value_a;
    assign value_B    = glb_q.value_b;
    assign load_A     = glb_q.load_a;
    assign load_B     = glb_q.load_b;
    assign en_irq_A   = glb_q.en_irq_a;
    assign en_irq_B   = glb_q.en_irq_b;
    assign csm        = glb_q.csm;
    assign clr_flag_A = glb_q.clr_a;
    assign clr_flag_B = glb_q.clr_b;
    assign lfo_rst    = glb_q.lfo_rst;
    assign lfo_freq   = glb_q.lfo_freq;
    assign amd        = glb_q.amd;
    assign pmd        = glb_q.pmd;
    assign lfo_w      = glb_q.lfo_w;
    assign ct         = glb_q.ct;
    assign ne         = glb_q.ne;
    assign nfrq       = glb_q.nfrq;

endmodule
